// File: rtl/charmatrix_pkg.sv
// Shared definitions for the 5x7 character matrix: geometry, scan states
// and the row-slice helper used by both the char ROM and the scanner.
package charmatrix_pkg;

    localparam int ROWS    = 7;
    localparam int COLS    = 5;
    localparam int GLYPH_W = 35;
    localparam int ROW_W   = $clog2(ROWS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // Row r lives in bits [34-5r : 30-5r]; the slice MSB is the leftmost column.
    function automatic logic [COLS-1:0] row_slice(input logic [GLYPH_W-1:0] glyph,
                                                  input logic [ROW_W-1:0]   row);
        logic [COLS-1:0] slice;
        slice = {COLS{1'b0}};
        for (int i = 0; i < ROWS; i++) begin
            if (row == ROW_W'(i)) begin
                slice = glyph[GLYPH_W-1-COLS*i -: COLS];
            end
        end
        return slice;
    endfunction

endpackage

// File: rtl/matrix_scanner_if.sv
// Glyph hand-off channel: a 5x7 bitmap offered with a valid/ready handshake.
interface matrix_scanner_if;
    import charmatrix_pkg::*;

    logic               glyph_valid;
    logic [GLYPH_W-1:0] glyph_data;
    logic               glyph_ready;

    modport master (output glyph_valid, output glyph_data, input glyph_ready);
    modport slave  (input glyph_valid, input glyph_data, output glyph_ready);

endinterface

// File: rtl/matrix_scanner.sv
// 5x7 LED matrix row scanner: double-buffered glyph, anti-ghost blanking
// before every row, glyph swaps only at frame boundaries.
module matrix_scanner
    import charmatrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    matrix_scanner_if.slave       glyph,
    output logic [ROWS-1:0]       row_sel,
    output logic [COLS-1:0]       col_data,
    output logic                  frame_start
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);

    scan_state_t        state_r;
    logic [ROW_W-1:0]   row_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [GLYPH_W-1:0] pending_r;
    logic               pending_valid_r;
    logic [GLYPH_W-1:0] active_r;
    logic               active_valid_r;
    logic               ready_r;
    logic [ROWS-1:0]    row_sel_r;
    logic [COLS-1:0]    col_data_r;
    logic               frame_start_r;

    scan_state_t        state_s;
    logic [ROW_W-1:0]   row_s;
    logic [CNT_W-1:0]   cnt_s;
    logic               load_s;
    logic               start_s;
    logic               accept_s;
    logic               pending_valid_s;
    logic [GLYPH_W-1:0] active_s;
    logic [ROWS-1:0]    row_sel_s;
    logic [COLS-1:0]    col_data_s;

    // Ready comes straight from a flop, so accept never depends combinationally on valid.
    assign accept_s = glyph.glyph_valid && ready_r;

    // Scan sequencing: next state, row, counter and the pending-to-active swap.
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        cnt_s   = cnt_r;
        load_s  = 1'b0;
        start_s = 1'b0;
        if (!enable) begin
            state_s = ST_IDLE;
            row_s   = {ROW_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pending_valid_r || active_valid_r) begin
                        state_s = ST_BLANK;
                        row_s   = {ROW_W{1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                        start_s = 1'b1;
                        load_s  = pending_valid_r;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        state_s = ST_DRIVE;
                        cnt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r == DWELL_LAST) begin
                        state_s = ST_BLANK;
                        cnt_s   = {CNT_W{1'b0}};
                        if (row_r == LAST_ROW) begin
                            // Frame boundary: the only point where the displayed glyph may change.
                            row_s   = {ROW_W{1'b0}};
                            start_s = 1'b1;
                            load_s  = pending_valid_r;
                        end else begin
                            row_s = row_r + ROW_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    row_s   = {ROW_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Buffer bookkeeping and the display values for the upcoming cycle.
    always_comb begin
        pending_valid_s = pending_valid_r;
        if (accept_s) begin
            pending_valid_s = 1'b1;
        end else if (load_s) begin
            pending_valid_s = 1'b0;
        end else begin
            pending_valid_s = pending_valid_r;
        end
        active_s   = load_s ? pending_r : active_r;
        row_sel_s  = {ROWS{1'b0}};
        col_data_s = {COLS{1'b0}};
        if (state_s == ST_DRIVE) begin
            row_sel_s  = {{(ROWS-1){1'b0}}, 1'b1} << row_s;
            col_data_s = row_slice(active_s, row_s);
        end else begin
            row_sel_s  = {ROWS{1'b0}};
            col_data_s = {COLS{1'b0}};
        end
    end

    // State, buffers and registered outputs; reset darkens the display at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            row_r           <= {ROW_W{1'b0}};
            cnt_r           <= {CNT_W{1'b0}};
            pending_r       <= {GLYPH_W{1'b0}};
            pending_valid_r <= 1'b0;
            active_r        <= {GLYPH_W{1'b0}};
            active_valid_r  <= 1'b0;
            ready_r         <= 1'b1;
            row_sel_r       <= {ROWS{1'b0}};
            col_data_r      <= {COLS{1'b0}};
            frame_start_r   <= 1'b0;
        end else begin
            state_r         <= state_s;
            row_r           <= row_s;
            cnt_r           <= cnt_s;
            pending_valid_r <= pending_valid_s;
            ready_r         <= !pending_valid_s;
            if (accept_s) begin
                pending_r <= glyph.glyph_data;
            end
            if (load_s) begin
                active_r       <= pending_r;
                active_valid_r <= 1'b1;
            end
            row_sel_r     <= row_sel_s;
            col_data_r    <= col_data_s;
            frame_start_r <= start_s;
        end
    end

    assign glyph.glyph_ready = ready_r;
    assign row_sel           = row_sel_r;
    assign col_data          = col_data_r;
    assign frame_start       = frame_start_r;

endmodule

// File: tb/tb_matrix_scanner.sv
// Self-checking bench for matrix_scanner: frame-position reference model,
// accept/display scoreboard, directed scenarios and a randomized soak.
module tb_matrix_scanner;
    import charmatrix_pkg::*;

    localparam int DW     = 4;
    localparam int BL     = 2;
    localparam int SLOT   = BL + DW;
    localparam int PERIOD = 7 * SLOT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [6:0]  row_sel;
    logic [4:0]  col_data;
    logic        frame_start;

    matrix_scanner_if bus();

    matrix_scanner #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .glyph       (bus),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [34:0] sb_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: position within the frame plus the two glyph buffers.
    logic        m_run;
    int          m_pos;
    logic [34:0] m_act, m_pend, m_loaded;
    logic        m_act_v, m_pend_v, m_load_ev;

    always @(posedge clk or posedge rst) begin : model
        logic run_n, ld, acc;
        int   pos_n;
        if (rst) begin
            m_run <= 1'b0; m_pos <= 0; m_act <= '0; m_act_v <= 1'b0;
            m_pend <= '0; m_pend_v <= 1'b0; m_load_ev <= 1'b0; m_loaded <= '0;
        end else begin
            acc   = bus.glyph_valid && !m_pend_v;
            ld    = 1'b0;
            run_n = m_run;
            pos_n = m_pos;
            if (!enable) begin
                run_n = 1'b0;
                pos_n = 0;
            end else if (m_run) begin
                pos_n = m_pos + 1;
                if (pos_n == PERIOD) begin
                    pos_n = 0;
                    ld    = m_pend_v;
                end
            end else if (m_pend_v || m_act_v) begin
                run_n = 1'b1;
                pos_n = 0;
                ld    = m_pend_v;
            end
            m_run     <= run_n;
            m_pos     <= pos_n;
            m_load_ev <= ld;
            if (ld) begin
                m_act    <= m_pend;
                m_act_v  <= 1'b1;
                m_loaded <= m_pend;
            end
            if (acc) begin
                m_pend   <= bus.glyph_data;
                m_pend_v <= 1'b1;
            end else if (ld) begin
                m_pend_v <= 1'b0;
            end
        end
    end

    // Every glyph the DUT accepts is queued for the in-order display check.
    always @(posedge clk) begin
        if (!rst && bus.glyph_valid && bus.glyph_ready) sb_q.push_back(bus.glyph_data);
    end

    always @(negedge clk) begin : compare
        int row, w;
        logic [6:0]  ers;
        logic [4:0]  ecol;
        logic        efs;
        logic [34:0] sh;
        logic [34:0] front;
        ers = '0; ecol = '0; efs = 1'b0;
        if (m_run) begin
            row = m_pos / SLOT;
            w   = m_pos % SLOT;
            efs = (m_pos == 0);
            if (w >= BL) begin
                ers  = 7'(1 << row);
                sh   = m_act >> (30 - 5 * row);
                ecol = sh[4:0];
            end
        end
        chk("ready", bus.glyph_ready, !m_pend_v);
        chk("row_sel", row_sel, ers);
        chk("col_data", col_data, ecol);
        chk("frame_start", frame_start, efs);
        if (m_load_ev) begin
            chk("sb_nonempty", 64'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                front = sb_q.pop_front();
                chk("sb_order", m_loaded, front);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 100);
        chk("fs_seen", frame_start, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lowcnt, acc, k;
        logic shown_a, bump;
        bus.glyph_valid = 1'b0;
        bus.glyph_data  = '0;
        step(3);
        chk("rst_ready", bus.glyph_ready, 1);
        chk("rst_row_sel", row_sel, 0);
        chk("rst_col", col_data, 0);
        chk("rst_fs", frame_start, 0);
        rst = 1'b0; enable = 1'b1;
        step(2);
        chk("idle_dark", {row_sel, col_data, frame_start}, 0);

        // First glyph: all LEDs lit
        bus.glyph_valid = 1'b1; bus.glyph_data = 35'h7_FFFF_FFFF;
        step(1); bus.glyph_valid = 1'b0;
        chk("031_ready_low", bus.glyph_ready, 0);
        step(1);
        chk("031_ready_back", bus.glyph_ready, 1);
        chk("031_fs", frame_start, 1);
        chk("031_blank0", {row_sel, col_data}, 0);
        step(1);
        chk("031_blank1", {row_sel, col_data, frame_start}, 0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("031_drive", {row_sel, col_data}, {7'b0000001, 5'b11111});
        end
        step(1);
        chk("031_blank_row1", row_sel, 0);

        // Single top-left pixel, frame period
        bus.glyph_valid = 1'b1; bus.glyph_data = 35'h4_0000_0000;
        step(1); bus.glyph_valid = 1'b0;
        wait_fs(n);
        step(2);
        chk("032_row0", {row_sel, col_data}, {7'b0000001, 5'b10000});
        step(6);
        chk("032_row1", {row_sel, col_data}, {7'b0000010, 5'b00000});
        wait_fs(n);
        chk("032_period", 8 + n, 42);

        // Mid-frame offer of B while A is shown
        step(10);
        bus.glyph_valid = 1'b1; bus.glyph_data = 35'h5_5555_5555;
        step(1); bus.glyph_valid = 1'b0;
        lowcnt = 0; shown_a = 1'b1;
        for (int i = 0; i < 100 && frame_start !== 1'b1; i++) begin
            if (!bus.glyph_ready) lowcnt++;
            if (col_data != 5'b00000) shown_a = 1'b0;
            step(1);
        end
        chk("033_ready_low_cycles", lowcnt, 31);
        chk("033_rows_show_a", shown_a, 1);
        chk("033_ready_at_wrap", bus.glyph_ready, 1);
        step(2);
        chk("033_b_row0", {row_sel, col_data}, {7'b0000001, 5'h15});

        // Disable during row 3, then re-enable
        step(18);
        chk("034_row3", row_sel, 7'b0001000);
        enable = 1'b0;
        step(1);
        chk("034_dark", {row_sel, col_data}, 0);
        step(3);
        chk("034_dark_hold", {row_sel, col_data, frame_start}, 0);
        enable = 1'b1;
        step(1);
        chk("034_fs", {frame_start, row_sel}, {1'b1, 7'b0});
        step(2);
        chk("034_row0", {row_sel, col_data}, {7'b0000001, 5'h15});

        // Async reset mid-DRIVE with a pending glyph
        bus.glyph_valid = 1'b1; bus.glyph_data = 35'h1_2345_6789;
        step(1); bus.glyph_valid = 1'b0;
        chk("035_pending", bus.glyph_ready, 0);
        @(posedge clk); #2;
        chk("035_driving", row_sel, 7'b0000001);
        rst = 1'b1; sb_q.delete();
        #1;
        chk("035_async_dark", {row_sel, col_data, frame_start}, 0);
        chk("035_async_ready", bus.glyph_ready, 1);
        step(1); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("035_idle", {bus.glyph_ready, frame_start, row_sel, col_data}, {1'b1, 13'b0});
        end

        // Valid held high: one accept per frame after the first
        #2; rst = 1'b1; sb_q.delete();
        step(1);
        rst = 1'b0; bus.glyph_valid = 1'b1;
        k = 0; bus.glyph_data = {3'(k), 32'(k * 32'h9E3779B1 + 1)};
        bump = 1'b0; acc = 0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) @(negedge clk);
            if (bump) begin
                k++;
                bus.glyph_data = {3'(k), 32'(k * 32'h9E3779B1 + 1)};
                bump = 1'b0;
            end
            if (bus.glyph_valid && bus.glyph_ready) begin
                acc++;
                bump = 1'b1;
            end
        end
        bus.glyph_valid = 1'b0;
        chk("036_accepts", acc, 4);

        // Randomized soak
        for (int i = 0; i < 2000; i++) begin
            step(1);
            if ($urandom_range(0, 39) == 0) enable = !enable;
            bus.glyph_valid = ($urandom_range(0, 3) == 0);
            bus.glyph_data  = 35'({$urandom(), $urandom()});
        end
        bus.glyph_valid = 1'b0; enable = 1'b1;
        step(3);
        chk("sb_residual", sb_q.size(), m_pend_v ? 1 : 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
